midi_msg_parser: RTL and testbench

- Sequences the byte stream from the MIDI UART receiver into complete channel-voice events for the synth voice logic.
- Tracks running status and filters on a selectable MIDI channel.
- Ignores real-time and system bytes.
- Presents one buffered event at a time on a valid/ready handshake in the audio clock domain.

---
 rtl/midi_msg_parser_pkg.sv | 32 +++
 rtl/midi_msg_parser.sv | 124 ++++++++++++
 tb/tb_midi_msg_parser.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/midi_msg_parser_pkg.sv
// Shared MIDI types, command nibbles and per-command helpers.
// MIDI_CC_EN: when defined, control change (0xB) is a supported command.
package midi_msg_parser_pkg;

  typedef logic [7:0] midi_byte_t;

  typedef enum logic [1:0] {
    NOTE_OFF = 2'd0,
    NOTE_ON  = 2'd1,
    CTRL     = 2'd2
  } midi_evt_t;

  localparam logic [3:0] MidiNoteOff  = 4'h8;
  localparam logic [3:0] MidiNoteOn   = 4'h9;
  localparam logic [3:0] MidiCtrl     = 4'hB;
  localparam logic [3:0] MidiProg     = 4'hC;
  localparam logic [3:0] MidiChPress  = 4'hD;
  localparam midi_byte_t MidiRtMin    = 8'hF8;

  function automatic logic [1:0] data_len(input logic [3:0] cmd);
    return (cmd == MidiProg || cmd == MidiChPress) ? 2'd1 : 2'd2;
  endfunction

  function automatic logic cmd_supported(input logic [3:0] cmd);
`ifdef MIDI_CC_EN
    return (cmd == MidiNoteOff) || (cmd == MidiNoteOn) || (cmd == MidiCtrl);
`else
    return (cmd == MidiNoteOff) || (cmd == MidiNoteOn);
`endif
  endfunction

endpackage

// File: rtl/midi_msg_parser.sv
// MIDI byte-stream parser: running status, channel filter, one-entry event buffer.
// MIDI_CC_EN (via package helpers) enables CTRL events for control change.
module midi_msg_parser
  import midi_msg_parser_pkg::*;
#(
  parameter int MaxSkipLen = 2
) (
  input  logic       i_clk_aud,
  input  logic       i_aud_rst_n,
  input  logic       i_valid,
  input  logic [7:0] i_midi_byte,
  input  logic [3:0] i_channel,
  output logic       o_evt_valid,
  input  logic       i_evt_ready,
  output logic [1:0] o_evt_type,
  output logic [6:0] o_evt_key,
  output logic [6:0] o_evt_val,
  output logic       o_overrun
);

  localparam int SkipW = $clog2(MaxSkipLen + 1);

  typedef enum logic [1:0] {
    NO_STATUS,
    WAIT_D1,
    WAIT_D2,
    SKIP
  } state_t;

  state_t           state;
  logic [3:0]       run_cmd;
  logic [6:0]       key_reg;
  logic [SkipW-1:0] skip_cnt;
  logic [SkipW-1:0] skip_len;

  logic             is_data;
  logic             is_sys;
  logic             is_rt;
  logic             is_chan;
  logic [3:0]       hi_nib;
  logic [SkipW-1:0] len_now;
  logic             match;
  midi_evt_t        evt_kind;

  always_comb begin
    hi_nib   = i_midi_byte[7:4];
    is_data  = ~i_midi_byte[7];
    is_rt    = (i_midi_byte >= MidiRtMin);
    is_sys   = (i_midi_byte[7:3] == 5'b11110);
    is_chan  = i_midi_byte[7] && !is_sys && !is_rt;
    len_now  = SkipW'(data_len(hi_nib));
    match    = (i_midi_byte[3:0] == i_channel) && cmd_supported(hi_nib);
    // A note-on with zero velocity is a note-off by MIDI convention.
    if (run_cmd == MidiCtrl)
      evt_kind = CTRL;
    else if (run_cmd == MidiNoteOn && i_midi_byte[6:0] != 7'd0)
      evt_kind = NOTE_ON;
    else
      evt_kind = NOTE_OFF;
  end

  always_ff @(posedge i_clk_aud or negedge i_aud_rst_n) begin
    if (!i_aud_rst_n) begin
      state       <= NO_STATUS;
      run_cmd     <= 4'h0;
      key_reg     <= 7'd0;
      skip_cnt    <= '0;
      skip_len    <= '0;
      o_evt_valid <= 1'b0;
      o_evt_type  <= 2'd0;
      o_evt_key   <= 7'd0;
      o_evt_val   <= 7'd0;
      o_overrun   <= 1'b0;
    end else begin
      o_overrun <= 1'b0;
      if (o_evt_valid && i_evt_ready)
        o_evt_valid <= 1'b0;

      if (i_valid) begin
        if (is_chan) begin
          run_cmd  <= hi_nib;
          skip_len <= len_now;
          if (match) begin
            state <= WAIT_D1;
          end else begin
            state    <= SKIP;
            skip_cnt <= len_now;
          end
        end else if (is_sys) begin
          run_cmd  <= 4'h0;
          state    <= NO_STATUS;
          skip_cnt <= '0;
        end else if (is_data) begin
          case (state)
            WAIT_D1: begin
              key_reg <= i_midi_byte[6:0];
              state   <= WAIT_D2;
            end
            WAIT_D2: begin
              state <= WAIT_D1;
              if (!o_evt_valid || i_evt_ready) begin
                o_evt_valid <= 1'b1;
                o_evt_type  <= evt_kind;
                o_evt_key   <= key_reg;
                o_evt_val   <= i_midi_byte[6:0];
              end else begin
                o_overrun <= 1'b1;
              end
            end
            SKIP: begin
              // Reload keeps skipping running-status repeats of a filtered message.
              if (skip_cnt == SkipW'(1))
                skip_cnt <= skip_len;
              else if (skip_cnt != '0)
                skip_cnt <= skip_cnt - SkipW'(1);
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_midi_msg_parser.sv
// Bench for midi_msg_parser: directed steps plus randomized message stream vs message-level model.
module tb_midi_msg_parser;

`ifdef MIDI_CC_EN
  localparam bit CcEn = 1'b1;
`else
  localparam bit CcEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       valid;
  logic [7:0] midi_byte;
  logic [3:0] channel;
  logic       evt_valid;
  logic       evt_ready;
  logic [1:0] evt_type;
  logic [6:0] evt_key;
  logic [6:0] evt_val;
  logic       overrun;

  int cmp_cnt = 0;
  int err_cnt = 0;
  int ovr_cnt = 0;
  logic [15:0] got_q[$];
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  midi_msg_parser dut (
    .i_clk_aud   (clk),
    .i_aud_rst_n (rst_n),
    .i_valid     (valid),
    .i_midi_byte (midi_byte),
    .i_channel   (channel),
    .o_evt_valid (evt_valid),
    .i_evt_ready (evt_ready),
    .o_evt_type  (evt_type),
    .o_evt_key   (evt_key),
    .o_evt_val   (evt_val),
    .o_overrun   (overrun)
  );

  always @(negedge clk) begin
    if (rst_n) begin
      if (evt_valid && evt_ready)
        got_q.push_back({evt_type, evt_key, evt_val});
      if (overrun)
        ovr_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    midi_byte = b;
    valid     = 1'b1;
    @(posedge clk);
    #1;
    valid     = 1'b0;
  endtask

  task automatic check_evt(input string tag, input logic [1:0] t, input logic [6:0] k,
                           input logic [6:0] v);
    logic [15:0] g;
    int w = 0;
    while (got_q.size() == 0 && w < 20) begin
      idle(1);
      w++;
    end
    chk({tag, "_present"}, got_q.size() > 0 ? 32'd1 : 32'd0, 32'd1);
    if (got_q.size() > 0) begin
      g = got_q.pop_front();
      chk(tag, {16'd0, g}, {16'd0, t, k, v});
    end
  endtask

  task automatic check_none(input string tag);
    idle(5);
    chk(tag, got_q.size(), 0);
    got_q.delete();
  endtask

  function automatic bit sup(input logic [3:0] cmd);
    return cmd == 4'h8 || cmd == 4'h9 || (CcEn && cmd == 4'hB);
  endfunction

  // Random stream helper: occasionally slips a real-time byte in front of b.
  task automatic rsend(input logic [7:0] b);
    if ($urandom_range(0, 4) == 0)
      send_byte(8'hF8 + 8'($urandom_range(0, 7)));
    send_byte(b);
    if ($urandom_range(0, 3) == 0)
      idle($urandom_range(1, 2));
  endtask

  initial begin
    logic [3:0] rs_cmd;
    logic [3:0] ch;
    logic [6:0] k, v;
    bit         rs_ok, rs_match;
    int         sel, nexp;

    rst_n = 1'b1; valid = 1'b0; midi_byte = 8'h00; channel = 4'h0; evt_ready = 1'b1;
    #2 rst_n = 1'b0;
    idle(3);
    chk("rst_valid", evt_valid, 0);
    chk("rst_fields", {evt_type, evt_key, evt_val}, 0);
    chk("rst_overrun", overrun, 0);
    rst_n = 1'b1;
    idle(2);

    // Single NOTE_ON and latency
    send_byte(8'h90); send_byte(8'h3C);
    chk("lat_before", evt_valid, 0);
    send_byte(8'h64);
    chk("lat_after", evt_valid, 1);
    check_evt("note_on", 2'd1, 7'h3C, 7'h64);
    idle(1);
    chk("valid_drop", evt_valid, 0);

    // Running status
    send_byte(8'h90); send_byte(8'h40); send_byte(8'h7F); send_byte(8'h40); send_byte(8'h00);
    check_evt("rs_on", 2'd1, 7'h40, 7'h7F);
    check_evt("rs_off", 2'd0, 7'h40, 7'h00);
    check_none("rs_extra");

    // Channel filter
    send_byte(8'h91); send_byte(8'h3C); send_byte(8'h64); send_byte(8'h3D); send_byte(8'h10);
    send_byte(8'h80); send_byte(8'h3C); send_byte(8'h00);
    check_evt("filter_off", 2'd0, 7'h3C, 7'h00);
    check_none("filter_extra");

    // Real-time interleave, then SysEx
    send_byte(8'h90); send_byte(8'h3C); send_byte(8'hF8); send_byte(8'h64);
    check_evt("rt_on", 2'd1, 7'h3C, 7'h64);
    send_byte(8'hF0); send_byte(8'h7E); send_byte(8'h01); send_byte(8'hF7); send_byte(8'h45);
    check_none("sysex");

    // Control change
    send_byte(8'hB0); send_byte(8'h07); send_byte(8'h64);
    if (CcEn) check_evt("cc", 2'd2, 7'h07, 7'h64);
    else      check_none("cc_off");

    // Backpressure
    evt_ready = 1'b0;
    ovr_cnt = 0;
    send_byte(8'h90); send_byte(8'h3C); send_byte(8'h64);
    chk("bp_valid", evt_valid, 1);
    send_byte(8'h3D); send_byte(8'h65);
    idle(3);
    chk("bp_overrun", ovr_cnt, 1);
    chk("bp_held", {evt_valid, evt_type, evt_key, evt_val}, {1'b1, 2'd1, 7'h3C, 7'h64});
    evt_ready = 1'b1;
    idle(1);
    chk("bp_release", evt_valid, 0);
    check_evt("bp_evt", 2'd1, 7'h3C, 7'h64);
    check_none("bp_extra");

    // Abandoned partial message
    send_byte(8'h90); send_byte(8'h3C); send_byte(8'h80); send_byte(8'h3C); send_byte(8'h00);
    check_evt("abandon", 2'd0, 7'h3C, 7'h00);
    check_none("abandon_extra");

    // Reset mid-message
    send_byte(8'h90); send_byte(8'h3C);
    rst_n = 1'b0;
    #1;
    chk("midrst_out", {evt_valid, evt_type, evt_key, evt_val, overrun}, 0);
    idle(2);
    rst_n = 1'b1;
    idle(1);
    send_byte(8'h50); send_byte(8'h51);
    check_none("midrst_none");

    // Randomized stream against message-level model
    channel = 4'($urandom_range(0, 15));
    ovr_cnt = 0;
    rs_ok = 0; rs_match = 0; rs_cmd = 4'h8;
    for (int n = 0; n < 300; n++) begin
      sel = $urandom_range(0, 9);
      if (sel <= 5 || !rs_ok || sel == 9) begin
        if (sel == 9) rs_cmd = 4'h8 + 4'($urandom_range(0, 3));
        else          rs_cmd = 4'h8 + 4'($urandom_range(0, 6));
        if (rs_cmd == 4'hB && sel == 9) rs_cmd = 4'hE;
        ch = ($urandom_range(0, 1) == 0) ? channel : 4'($urandom_range(0, 15));
        rs_match = (ch == channel) && sup(rs_cmd);
        rsend({rs_cmd, ch});
        rs_ok = 1;
      end
      if (sel == 8 && rs_ok) begin
        rsend(8'hF0);
        for (int j = 0; j < $urandom_range(0, 3); j++) rsend(8'($urandom_range(0, 127)));
        rsend(8'hF7);
        rs_ok = 0;
      end else if (sel == 9) begin
        rsend(8'($urandom_range(0, 127)));
        rs_ok = 0;
      end else begin
        k = 7'($urandom_range(0, 127));
        v = ($urandom_range(0, 3) == 0) ? 7'd0 : 7'($urandom_range(0, 127));
        rsend({1'b0, k});
        if (!(rs_cmd == 4'hC || rs_cmd == 4'hD)) begin
          rsend({1'b0, v});
          if (rs_match)
            exp_q.push_back({(rs_cmd == 4'hB) ? 2'd2 : (rs_cmd == 4'h9 && v != 0) ? 2'd1 : 2'd0,
                             k, v});
        end
      end
    end
    idle(10);
    chk("rand_count", got_q.size(), exp_q.size());
    chk("rand_overrun", ovr_cnt, 0);
    nexp = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < nexp; i++)
      chk($sformatf("rand_evt%0d", i), {16'd0, got_q[i]}, {16'd0, exp_q[i]});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
